// File: rtl/qspi_rom_responder.sv
// QSPI flash target serving Fast Read Quad I/O (0xEB) from an internal ROM image.
// Optional feature: define QSPI_CONTINUOUS_READ_EN to honour the W25Q-style continuous-read mode byte.
module qspi_rom_responder #(
    parameter int          DEPTH     = 4096,
    parameter logic [23:0] BASE_ADDR = 24'h100000,
    parameter string       INIT_FILE = "rom_builtin.mem"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_select,
    input  logic        spi_clk,
    input  logic [3:0]  spi_data_in,
    output logic [3:0]  spi_data_out,
    output logic [3:0]  spi_data_oe,
    output logic [15:0] bytes_served,
    output logic        cmd_error
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE
    } state_t;

    logic [7:0]  mem [DEPTH];

    state_t      state_r;
    logic        sck_q;
    logic [2:0]  cnt_r;
    logic [7:0]  shift_r;
    logic [23:0] addr_r;
    logic [7:0]  data_r;
    logic        nib_lo_r;
    logic        cont_mode_r;
    logic        rise_s;
    logic        fall_s;

    // Anything outside the mapped window reads back as erased flash.
    function automatic logic [7:0] fetch_byte(input logic [23:0] a);
        logic [23:0] off;
        off = a - BASE_ADDR;
        if (off < 24'(DEPTH)) begin
            return mem[off[AW-1:0]];
        end else begin
            return 8'hFF;
        end
    endfunction

    // SCK edge detection against the previous clk sample.
    always_comb begin
        rise_s = spi_clk & ~sck_q;
        fall_s = ~spi_clk & sck_q;
    end

    // Transaction state machine with registered pad outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            sck_q        <= 1'b0;
            cnt_r        <= 3'd0;
            shift_r      <= 8'd0;
            addr_r       <= 24'd0;
            data_r       <= 8'd0;
            nib_lo_r     <= 1'b0;
            cont_mode_r  <= 1'b0;
            spi_data_out <= 4'd0;
            spi_data_oe  <= 4'd0;
            bytes_served <= 16'd0;
            cmd_error    <= 1'b0;
        end else begin
            sck_q     <= spi_clk;
            cmd_error <= 1'b0;
            // Deselect overrides any SCK edge seen in the same clk.
            if (spi_select) begin
                state_r     <= IDLE;
                spi_data_oe <= 4'd0;
                cnt_r       <= 3'd0;
                addr_r      <= 24'd0;
                nib_lo_r    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        cnt_r    <= 3'd0;
                        nib_lo_r <= 1'b0;
                        state_r  <= cont_mode_r ? ADDR : CMD;
                    end
                    CMD: begin
                        if (rise_s) begin
                            shift_r <= {shift_r[6:0], spi_data_in[0]};
                            if (cnt_r == 3'd7) begin
                                cnt_r <= 3'd0;
                                if ({shift_r[6:0], spi_data_in[0]} == 8'hEB) begin
                                    state_r <= ADDR;
                                end else begin
                                    state_r   <= IGNORE;
                                    cmd_error <= 1'b1;
                                end
                            end else begin
                                cnt_r <= cnt_r + 3'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (rise_s) begin
                            addr_r <= {addr_r[19:0], spi_data_in};
                            if (cnt_r == 3'd5) begin
                                cnt_r   <= 3'd0;
                                state_r <= MODE;
                            end else begin
                                cnt_r <= cnt_r + 3'd1;
                            end
                        end
                    end
                    MODE: begin
                        if (rise_s) begin
                            shift_r <= {shift_r[3:0], spi_data_in};
                            if (cnt_r == 3'd1) begin
                                cnt_r   <= 3'd0;
                                state_r <= DUMMY;
`ifdef QSPI_CONTINUOUS_READ_EN
                                // Mode bits [5:4] arrive as the low half of the first mode nibble.
                                cont_mode_r <= (shift_r[1:0] == 2'b10);
`else
                                cont_mode_r <= 1'b0;
`endif
                            end else begin
                                cnt_r <= cnt_r + 3'd1;
                            end
                        end
                    end
                    DUMMY: begin
                        if (rise_s) begin
                            if (cnt_r == 3'd3) begin
                                cnt_r    <= 3'd0;
                                state_r  <= DATA;
                                data_r   <= fetch_byte(addr_r);
                                nib_lo_r <= 1'b0;
                            end else begin
                                cnt_r <= cnt_r + 3'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (fall_s) begin
                            spi_data_oe <= 4'hF;
                            if (!nib_lo_r) begin
                                spi_data_out <= data_r[7:4];
                                nib_lo_r     <= 1'b1;
                            end else begin
                                // Prefetch the next byte while its predecessor's low nibble goes out.
                                spi_data_out <= data_r[3:0];
                                nib_lo_r     <= 1'b0;
                                addr_r       <= addr_r + 24'd1;
                                bytes_served <= bytes_served + 16'd1;
                                data_r       <= fetch_byte(addr_r + 24'd1);
                            end
                        end
                    end
                    IGNORE: begin
                        spi_data_oe <= 4'd0;
                    end
                    default: begin
                        state_r     <= IDLE;
                        spi_data_oe <= 4'd0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qspi_rom_responder.sv
// Self-checking bench for qspi_rom_responder: directed and random 0xEB reads against a byte-level model.
module tb_qspi_rom_responder;
    logic        clk;
    logic        rst_n;
    logic        spi_select;
    logic        spi_clk;
    logic [3:0]  spi_data_in;
    logic [3:0]  spi_data_out;
    logic [3:0]  spi_data_oe;
    logic [15:0] bytes_served;
    logic        cmd_error;

    int          errors = 0;
    int          checks = 0;
    int          err_pulses = 0;
    logic [7:0]  model_mem [4096];
    int          model_bytes = 0;
    bit          model_cont = 1'b0;

    qspi_rom_responder #(
        .DEPTH(4096), .BASE_ADDR(24'h100000), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst_n(rst_n), .spi_select(spi_select), .spi_clk(spi_clk),
        .spi_data_in(spi_data_in), .spi_data_out(spi_data_out), .spi_data_oe(spi_data_oe),
        .bytes_served(bytes_served), .cmd_error(cmd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_error === 1'b1) err_pulses++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] ref_byte(input logic [23:0] a);
        int off;
        off = int'(a) - 32'h100000;
        if (off >= 0 && off < 4096) return model_mem[off];
        return 8'hFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sck(input logic [3:0] nib);
        @(negedge clk);
        spi_data_in = nib;
        spi_clk = 1'b1;
        repeat (2) @(negedge clk);
        spi_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic select_lo();
        @(negedge clk);
        spi_select = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic deselect();
        @(negedge clk);
        spi_select = 1'b1;
        spi_data_in = 4'd0;
        repeat (2) @(negedge clk);
        chk("deselect_oe", 32'(spi_data_oe), 32'h0);
    endtask

    task automatic send_serial(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sck({3'b000, b[i]});
    endtask

    task automatic do_read(input logic [23:0] a, input logic [7:0] mode, input int nbytes);
        logic [23:0] cur;
        logic [7:0]  exp;
        int          pulses0;
        pulses0 = err_pulses;
        select_lo();
        if (!model_cont) send_serial(8'hEB);
        for (int i = 5; i >= 0; i--) sck(a[i*4 +: 4]);
        chk("oe_before_data", 32'(spi_data_oe), 32'h0);
        sck(mode[7:4]);
        sck(mode[3:0]);
`ifdef QSPI_CONTINUOUS_READ_EN
        model_cont = (mode[5:4] == 2'b10);
`endif
        for (int i = 0; i < 4; i++) sck(4'd0);
        cur = a;
        for (int n = 0; n < 2 * nbytes; n++) begin
            if (n > 0) sck(4'd0);
            exp = ref_byte(cur);
            chk("data_oe", 32'(spi_data_oe), 32'hF);
            if (n % 2 == 0) begin
                chk("data_hi", 32'(spi_data_out), 32'(exp[7:4]));
            end else begin
                chk("data_lo", 32'(spi_data_out), 32'(exp[3:0]));
                model_bytes = (model_bytes + 1) % 65536;
                cur = cur + 24'd1;
                chk("bytes_served", 32'(bytes_served), 32'(model_bytes));
            end
        end
        chk("no_cmd_error", 32'(err_pulses - pulses0), 32'h0);
        deselect();
    endtask

    initial begin
        logic [7:0]  b;
        logic [23:0] ra;
        int          pulses0;
        int          bytes0;
        rst_n = 1'b0;
        spi_select = 1'b1;
        spi_clk = 1'b0;
        spi_data_in = 4'd0;
        for (int i = 0; i < 4096; i++) begin
            b = 8'($urandom);
            model_mem[i] = b;
            dut.mem[i] = b;
        end
        model_mem[0] = 8'hA9; dut.mem[0] = 8'hA9;
        model_mem[1] = 8'h00; dut.mem[1] = 8'h00;
        model_mem[2] = 8'h85; dut.mem[2] = 8'h85;

        // T1 reset
        repeat (2) @(negedge clk);
        chk("reset_oe", 32'(spi_data_oe), 32'h0);
        chk("reset_out", 32'(spi_data_out), 32'h0);
        chk("reset_bytes", 32'(bytes_served), 32'h0);
        chk("reset_cmd_error", 32'(cmd_error), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T2 basic read
        do_read(24'h100000, 8'h00, 3);

        // T3 unsupported opcode
        pulses0 = err_pulses;
        select_lo();
        send_serial(8'h03);
        repeat (3) @(negedge clk);
        chk("cmd_error_pulse", 32'(err_pulses - pulses0), 32'h1);
        for (int i = 0; i < 6; i++) begin
            sck(4'($urandom));
            chk("ignore_oe", 32'(spi_data_oe), 32'h0);
        end
        deselect();
        do_read(24'h100000, 8'h00, 1);

        // T4 abort during address phase
        bytes0 = model_bytes;
        select_lo();
        send_serial(8'hEB);
        sck(4'h1); sck(4'h0); sck(4'h0);
        deselect();
        chk("abort_bytes_kept", 32'(bytes_served), 32'(bytes0));
        do_read(24'h100001, 8'h00, 1);

        // T5 window edges
        do_read(24'h100FFF, 8'h00, 2);
        do_read(24'h0FFFFF, 8'h00, 1);
        do_read(24'h0FFFFE, 8'h00, 3);

        // Random reads around the window
        for (int k = 0; k < 8; k++) begin
            ra = 24'h0FFFF8 + 24'($urandom_range(0, 4120));
            do_read(ra, 8'($urandom), int'($urandom_range(1, 4)));
        end

        // T6 continuous read (without the feature, mode A0 must still leave opcode required)
        do_read(24'h100000, 8'h00, 1);
        do_read(24'h100000, 8'hA0, 1);
        do_read(24'h100002, 8'h00, 1);
        do_read(24'h100000, 8'h00, 1);

        // Reset mid-transfer
        select_lo();
        if (!model_cont) send_serial(8'hEB);
        for (int i = 0; i < 6; i++) sck(4'd0);
        for (int i = 0; i < 7; i++) sck(4'd0);
        @(negedge clk);
        rst_n = 1'b0;
        spi_select = 1'b1;
        @(negedge clk);
        chk("midreset_oe", 32'(spi_data_oe), 32'h0);
        chk("midreset_out", 32'(spi_data_out), 32'h0);
        chk("midreset_bytes", 32'(bytes_served), 32'h0);
        rst_n = 1'b1;
        model_bytes = 0;
        model_cont = 1'b0;
        repeat (2) @(negedge clk);
        do_read(24'h100000, 8'h00, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
